// File: rtl/mole_game_core.sv
// mole_game_core -- parametrised whack-a-mole engine.
//
// One mole is lit per round. The hole is picked by an 8-bit LFSR. The mole
// times out after UP_TICKS game ticks, and the round ends with a dark gap of
// GAP_TICKS ticks. A game is ROUNDS moles long. Hits and misses are counted in
// saturating counters. Button rising edges are detected here, so the
// btn inputs must already be debounced and synchronised.
//
// Ports
//   clk        system clock
//   clear_n    synchronous active-low reset
//   tick       1-cycle game-rate strobe
//   start      1-cycle request to begin or restart a game (IDLE/DONE only)
//   btn        debounced button levels, one per hole
//   led        one-hot lit mole, else 0
//   hit_pulse  1-cycle pulse on a correct whack
//   miss_pulse 1-cycle pulse on a wrong press or a timeout
//   score      hits this game (saturating)
//   misses     wrong presses + timeouts this game (saturating)
//   busy       game in progress (SPAWN/UP/GAP)
//   game_over  all rounds played, held until start
module mole_game_core #(
  parameter int         N_HOLES   = 5,
  parameter int         SCORE_W   = 8,
  parameter int         UP_TICKS  = 4,
  parameter int         GAP_TICKS = 1,
  parameter int         ROUNDS    = 16,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               tick,
  input  logic               start,
  input  logic [N_HOLES-1:0] btn,
  output logic [N_HOLES-1:0] led,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic               busy,
  output logic               game_over
);

  localparam int IDX_W   = $clog2(N_HOLES);
  localparam int T_MAX   = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int TIMER_W = $clog2(T_MAX + 1);
  localparam int ROUND_W = $clog2(ROUNDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_UP,
    S_GAP,
    S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [7:0]           lfsr_reg;
  logic [N_HOLES-1:0]   btn_q_reg;
  logic [N_HOLES-1:0]   press_reg;
  logic [IDX_W-1:0]     mole_idx_reg, mole_idx_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [ROUND_W-1:0]   round_reg, round_next;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic [SCORE_W-1:0]   misses_reg, misses_next;
  logic                 hit_reg, hit_next;
  logic                 miss_reg, miss_next;
  logic [N_HOLES-1:0]   mole_mask;
  logic                 correct_press;
  logic                 wrong_press;

  // Decoded position of the current mole; also drives the LEDs while UP.
  genvar gi;
  generate
    for (gi = 0; gi < N_HOLES; gi++) begin : g_mask
      assign mole_mask[gi] = (mole_idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign correct_press = |(press_reg & mole_mask);
  assign wrong_press   = |(press_reg & ~mole_mask);

  always_comb begin
    state_next    = state_reg;
    mole_idx_next = mole_idx_reg;
    timer_next    = timer_reg;
    round_next    = round_reg;
    score_next    = score_reg;
    misses_next   = misses_reg;
    hit_next      = 1'b0;
    miss_next     = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next  = S_SPAWN;
          score_next  = '0;
          misses_next = '0;
          round_next  = '0;
        end
      end
      S_SPAWN: begin
        mole_idx_next = IDX_W'(lfsr_reg % 8'(N_HOLES));
        timer_next    = TIMER_W'(UP_TICKS);
        state_next    = S_UP;
      end
      S_UP: begin
        // A correct press wins over a wrong one and over an expiring tick.
        if (correct_press) begin
          score_next = (score_reg == '1) ? score_reg : score_reg + 1'b1;
          hit_next   = 1'b1;
          timer_next = TIMER_W'(GAP_TICKS);
          state_next = S_GAP;
        end else if (wrong_press) begin
          misses_next = (misses_reg == '1) ? misses_reg : misses_reg + 1'b1;
          miss_next   = 1'b1;
        end else if (tick) begin
          if (timer_reg == TIMER_W'(1)) begin
            misses_next = (misses_reg == '1) ? misses_reg : misses_reg + 1'b1;
            miss_next   = 1'b1;
            timer_next  = TIMER_W'(GAP_TICKS);
            state_next  = S_GAP;
          end else begin
            timer_next = timer_reg - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (timer_reg == TIMER_W'(1)) begin
            round_next = round_reg + 1'b1;
            state_next = (round_next == ROUND_W'(ROUNDS)) ? S_DONE : S_SPAWN;
          end else begin
            timer_next = timer_reg - 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_reg    <= S_IDLE;
      lfsr_reg     <= SEED;
      btn_q_reg    <= '0;
      press_reg    <= '0;
      mole_idx_reg <= '0;
      timer_reg    <= '0;
      round_reg    <= '0;
      score_reg    <= '0;
      misses_reg   <= '0;
      hit_reg      <= 1'b0;
      miss_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running every cycle.
      lfsr_reg     <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      btn_q_reg    <= btn;
      // Registered edge detect: a press reaches the FSM one cycle after
      // the edge, giving the 2-cycle press-to-hit latency.
      press_reg    <= btn & ~btn_q_reg;
      mole_idx_reg <= mole_idx_next;
      timer_reg    <= timer_next;
      round_reg    <= round_next;
      score_reg    <= score_next;
      misses_reg   <= misses_next;
      hit_reg      <= hit_next;
      miss_reg     <= miss_next;
    end
  end

  assign led        = (state_reg == S_UP) ? mole_mask : '0;
  assign hit_pulse  = hit_reg;
  assign miss_pulse = miss_reg;
  assign score      = score_reg;
  assign misses     = misses_reg;
  assign busy       = (state_reg == S_SPAWN) || (state_reg == S_UP) || (state_reg == S_GAP);
  assign game_over  = (state_reg == S_DONE);

endmodule
